// File: rtl/spi_buffer_pkg.sv
// Shared types and constants for the SPI transfer-buffer write sequencer.
package spi_buffer_pkg;

    localparam int          ADDR_W_DEFAULT = 10;
    localparam int          BUF_BYTES      = 1024;
    localparam logic [15:0] CRC16_POLY     = 16'h1021;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// One-byte CRC-16/XMODEM step (poly 0x1021, MSB first, no reflection).
module crc16_ccitt_byte
    import spi_buffer_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    always_comb begin
        logic [15:0] c;
        // NOTE: c is fully assigned before any read on every pass, so no latch is inferred.
        c = crc_i ^ {data_i, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/spi_buffer_fill.sv
// Turns a valid/ready byte stream into wrapping buffer writes and tracks length/Busy/Done.
// Define SPI_FILL_CRC16_EN to compute CRC-16/XMODEM over the written bytes.
module spi_buffer_fill
    import spi_buffer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [ADDR_W-1:0] Length,
    input  logic              Abort,
    input  logic              RxValid,
    input  logic [7:0]        RxData,
    output logic              RxReady,
    output logic              WriteEnable,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [7:0]        WriteData,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W:0]   ByteCount,
    output logic [15:0]       Crc16
);

    fill_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remaining_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W:0]   count_q;
    logic [7:0]        wr_data_q;
    logic              wr_en_q;
    logic              rx_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              accept;

    // Abort wins over a byte offered in the same cycle.
    assign accept = RxValid && rx_ready_q && !Abort;

`ifdef SPI_FILL_CRC16_EN
    logic [15:0] crc_q;
    logic [15:0] crc_d;

    crc16_ccitt_byte u_crc (
        .crc_i  (crc_q),
        .data_i (RxData),
        .crc_o  (crc_d)
    );

    assign Crc16 = crc_q;
`else
    assign Crc16 = 16'h0000;
`endif

    // NOTE: registers use <= only, so every update sees pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            count_q     <= '0;
            wr_en_q     <= 1'b0;
            rx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SPI_FILL_CRC16_EN
            crc_q       <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start && !Abort) begin
                        addr_q      <= StartAddr;
                        remaining_q <= Length;
                        count_q     <= '0;
`ifdef SPI_FILL_CRC16_EN
                        crc_q       <= '0;
`endif
                        state_q     <= FILL;
                        rx_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                FILL: begin
                    if (Abort) begin
                        state_q    <= IDLE;
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (accept) begin
                        wr_en_q     <= 1'b1;
                        wr_addr_q   <= addr_q;
                        wr_data_q   <= RxData;
                        count_q     <= count_q + (ADDR_W + 1)'(1);
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - ADDR_W'(1);
`ifdef SPI_FILL_CRC16_EN
                        crc_q       <= crc_d;
`endif
                        if (remaining_q == '0) begin
                            state_q    <= DONE;
                            rx_ready_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign RxReady     = rx_ready_q;
    assign WriteEnable = wr_en_q;
    assign WriteAddr   = wr_addr_q;
    assign WriteData   = wr_data_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign ByteCount   = count_q;

endmodule

// File: tb/tb_spi_buffer_fill.sv
// Directed self-checking bench for spi_buffer_fill (CRC expectation follows SPI_FILL_CRC16_EN).
module tb_spi_buffer_fill;

    localparam int AW = 10;
`ifdef SPI_FILL_CRC16_EN
    localparam logic [15:0] EXP_CRC_123456789 = 16'h31C3;
`else
    localparam logic [15:0] EXP_CRC_123456789 = 16'h0000;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [AW-1:0] StartAddr = '0;
    logic [AW-1:0] Length = '0;
    logic          Abort = 1'b0;
    logic          RxValid = 1'b0;
    logic [7:0]    RxData = '0;
    logic          RxReady;
    logic          WriteEnable;
    logic [AW-1:0] WriteAddr;
    logic [7:0]    WriteData;
    logic          Busy;
    logic          Done;
    logic [AW:0]   ByteCount;
    logic [15:0]   Crc16;

    spi_buffer_fill dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .StartAddr   (StartAddr),
        .Length      (Length),
        .Abort       (Abort),
        .RxValid     (RxValid),
        .RxData      (RxData),
        .RxReady     (RxReady),
        .WriteEnable (WriteEnable),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData),
        .Busy        (Busy),
        .Done        (Done),
        .ByteCount   (ByteCount),
        .Crc16       (Crc16)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_timeouts = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    int          cyc = 0;
    logic        prev_acc = 1'b0;
    int          we_err = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_acc_cyc = 0;
    logic [AW:0] done_bc = '0;
    logic [15:0] done_crc = '0;
    logic        done_busy = 1'b0;
    int          wa_q[$];
    int          wd_q[$];
    int          exp_d[$];

    always @(negedge Clk) begin
        cyc++;
        if (WriteEnable !== prev_acc) we_err++;
        if (WriteEnable === 1'b1) begin
            wa_q.push_back(int'(WriteAddr));
            wd_q.push_back(int'(WriteData));
        end
        if (Done === 1'b1) begin
            done_cnt++;
            done_cyc  = cyc;
            done_bc   = ByteCount;
            done_crc  = Crc16;
            done_busy = Busy;
        end
        prev_acc = RxValid && RxReady && !Abort && !Reset;
        if (prev_acc) last_acc_cyc = cyc;
    end

    task automatic mon_clear();
        wa_q.delete();
        wd_q.delete();
        exp_d.delete();
        done_cnt = 0;
        we_err   = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic start_fill(input logic [AW-1:0] a, input logic [AW-1:0] l);
        Start = 1'b1; StartAddr = a; Length = l;
        tick(1);
        Start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int guard = 0;
        RxValid = 1'b1;
        RxData  = b;
        forever begin
            @(negedge Clk);
            if (RxReady === 1'b1) break;
            guard++;
            if (guard > 100) begin
                n_timeouts++;
                break;
            end
        end
        @(posedge Clk);
        #1;
        RxValid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_cnt == 0 && guard < 200) begin
            @(negedge Clk);
            guard++;
        end
        if (done_cnt == 0) n_timeouts++;
        tick(1);
    endtask

    task automatic check_writes(input string tag, input int base);
        int ae = 0;
        int de = 0;
        check({tag, "_wr_count"}, wa_q.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < wa_q.size(); i++) begin
            if (wa_q[i] != ((base + i) % 1024)) ae++;
            if (wd_q[i] != exp_d[i]) de++;
        end
        check({tag, "_wr_addr_errs"}, ae, 0);
        check({tag, "_wr_data_errs"}, de, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge Clk);
        check({tag, "_rxready"}, 32'(RxReady), 0);
        check({tag, "_we"}, 32'(WriteEnable), 0);
        check({tag, "_waddr"}, 32'(WriteAddr), 0);
        check({tag, "_wdata"}, 32'(WriteData), 0);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_done"}, 32'(Done), 0);
        check({tag, "_bytecount"}, 32'(ByteCount), 0);
        check({tag, "_crc"}, 32'(Crc16), 0);
    endtask

    initial begin
        logic [7:0] t1 [4];
        logic [7:0] t2 [4];
        logic [7:0] ascii [9];
        t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        t2 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        // Reset values
        tick(3);
        check_reset_outputs("reset");
        tick(1);
        Reset = 1'b0;
        tick(2);

        // Basic 4-byte fill from address 0, back-to-back
        mon_clear();
        start_fill(10'h000, 10'd3);
        check("t1_busy_after_start", 32'(Busy), 1);
        check("t1_rxready_after_start", 32'(RxReady), 1);
        for (int i = 0; i < 4; i++) begin
            push_byte(t1[i]);
            exp_d.push_back(int'(t1[i]));
        end
        check("t1_rxready_after_last", 32'(RxReady), 0);
        check("t1_busy_in_done_state", 32'(Busy), 1);
        wait_done();
        tick(3);
        check_writes("t1", 0);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_done_latency", done_cyc - last_acc_cyc, 2);
        check("t1_done_bytecount", 32'(done_bc), 4);
        check("t1_busy_at_done", 32'(done_busy), 0);
        check("t1_bytecount_hold", 32'(ByteCount), 4);
        check("t1_we_vs_accept", we_err, 0);

        // Wrapping address with RxValid bubbles
        mon_clear();
        start_fill(10'h3FE, 10'd3);
        check("t2_crc_cleared", 32'(Crc16), 0);
        check("t2_bytecount_cleared", 32'(ByteCount), 0);
        for (int i = 0; i < 4; i++) begin
            push_byte(t2[i]);
            exp_d.push_back(int'(t2[i]));
            tick(i + 1);
        end
        wait_done();
        check_writes("t2", 10'h3FE);
        check("t2_done_pulses", done_cnt, 1);
        check("t2_bytecount", 32'(done_bc), 4);
        check("t2_we_vs_accept", we_err, 0);

        // Full 1024-byte fill from a non-zero start address
        mon_clear();
        start_fill(10'h005, 10'd1023);
        for (int i = 0; i < 1024; i++) begin
            push_byte(8'(i));
            exp_d.push_back(i & 255);
        end
        check("t3_rxready_after_last", 32'(RxReady), 0);
        wait_done();
        tick(3);
        check_writes("t3", 5);
        check("t3_done_pulses", done_cnt, 1);
        check("t3_bytecount", 32'(done_bc), 32'h400);
        check("t3_we_vs_accept", we_err, 0);

        // Abort after 5 of 10 bytes; a Start during FILL is ignored
        mon_clear();
        start_fill(10'h000, 10'd9);
        for (int i = 0; i < 2; i++) begin
            push_byte(8'h50 + 8'(i));
            exp_d.push_back(8'h50 + i);
        end
        Start = 1'b1; StartAddr = 10'h200; Length = 10'd2;
        tick(1);
        Start = 1'b0;
        for (int i = 2; i < 5; i++) begin
            push_byte(8'h50 + 8'(i));
            exp_d.push_back(8'h50 + i);
        end
        Abort = 1'b1; RxValid = 1'b1; RxData = 8'hEE;
        @(negedge Clk);
        check("t4_busy_during_abort", 32'(Busy), 1);
        @(posedge Clk);
        #1;
        Abort = 1'b0; RxValid = 1'b0;
        check("t4_busy_after_abort", 32'(Busy), 0);
        check("t4_rxready_after_abort", 32'(RxReady), 0);
        tick(5);
        check_writes("t4", 0);
        check("t4_no_done", done_cnt, 0);
        check("t4_bytecount", 32'(ByteCount), 5);
        check("t4_we_vs_accept", we_err, 0);

        // Abort together with Start in IDLE does not start a fill
        Start = 1'b1; Abort = 1'b1; StartAddr = 10'h100; Length = 10'd0;
        tick(1);
        Start = 1'b0; Abort = 1'b0;
        check("t4_idle_abort_busy", 32'(Busy), 0);
        check("t4_idle_abort_rxready", 32'(RxReady), 0);
        check("t4_idle_abort_bytecount", 32'(ByteCount), 5);

        // CRC over "123456789"
        mon_clear();
        start_fill(10'h000, 10'd8);
        for (int i = 0; i < 9; i++) begin
            push_byte(ascii[i]);
            exp_d.push_back(int'(ascii[i]));
        end
        wait_done();
        check_writes("t5", 0);
        check("t5_bytecount", 32'(done_bc), 9);
        check("t5_crc_at_done", 32'(done_crc), 32'(EXP_CRC_123456789));
        check("t5_crc_hold", 32'(Crc16), 32'(EXP_CRC_123456789));

        // Reset mid-fill, then a normal fill
        mon_clear();
        start_fill(10'h040, 10'd7);
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
        RxValid = 1'b1; RxData = 8'h99; Reset = 1'b1;
        tick(1);
        RxValid = 1'b0;
        check_reset_outputs("midreset");
        tick(1);
        Reset = 1'b0;
        tick(4);
        check("t6_no_writes_after_reset", wa_q.size(), 3);
        check("t6_we_vs_accept", we_err, 0);
        mon_clear();
        start_fill(10'h010, 10'd1);
        push_byte(8'h5A); exp_d.push_back(8'h5A);
        push_byte(8'hA5); exp_d.push_back(8'hA5);
        wait_done();
        tick(2);
        check_writes("t6", 10'h010);
        check("t6_done_pulses", done_cnt, 1);
        check("t6_bytecount", 32'(done_bc), 2);
        check("t6_we_vs_accept_after", we_err, 0);

        check("handshake_timeouts", n_timeouts, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_buffer_fill.md
Name: spi_buffer_fill

Overview:
Write-side sequencer for the 1024-byte transfer buffer (8-bit write port, 16-bit read port to the cartridge bus). It takes a byte stream from the SPI/SD receiver through a valid/ready handshake and turns it into buffer writes with an auto-incrementing, wrapping address. It also counts bytes against a programmed length and reports Busy/Done. It runs entirely in the buffer's write-clock domain.

Parameters:
ADDR_W, 10, buffer byte-address width; the buffer holds 2^ADDR_W bytes.

Ports:
Clk  in  1  write-side clock; one clock, everything on posedge
Reset  in  1  synchronous, active-high reset
Start  in  1  one-cycle pulse; begins a fill (accepted only in IDLE)
StartAddr  in  ADDR_W  first byte address of the fill
Length  in  ADDR_W  byte count minus one (0 = 1 byte, 1023 = 1024 bytes)
Abort  in  1  terminates a fill immediately
RxValid  in  1  receiver byte valid
RxData  in  8  receiver byte
RxReady  out  1  block accepts RxData this cycle
WriteEnable  out  1  buffer write strobe
WriteAddr  out  ADDR_W  buffer byte address
WriteData  out  8  buffer write data
Busy  out  1  fill in progress
Done  out  1  one-cycle pulse on normal completion
ByteCount  out  ADDR_W+1  bytes written in the current or last fill
Crc16  out  16  CRC of the bytes written (feature-dependent)

Behaviour:
- Reset: state IDLE. RxReady=0, WriteEnable=0, WriteAddr=0, WriteData=0, Busy=0, Done=0, ByteCount=0, Crc16=0.
- States: IDLE, FILL, DONE.
- IDLE -> FILL on Start=1 with Abort=0:
  - Latch StartAddr into the address counter and Length into the remaining counter.
  - Clear ByteCount and Crc16.
  - Busy rises the cycle after Start.
- RxReady is 1 exactly while the state is FILL. It is registered from state, not combinational on RxValid.
- Accept = RxValid && RxReady. Accept in cycle N produces all of the following in cycle N+1:
  - WriteEnable=1, WriteAddr = current address, WriteData = RxData.
  - ByteCount incremented; address incremented modulo 2^ADDR_W (1023 wraps to 0); remaining counter decremented.
- The accept on which remaining==0 is the last byte:
  - The state goes to DONE, so RxReady=0 in cycle N+1.
  - The final write occurs in N+1, and DONE is also the state in N+1.
  - Done=1 in cycle N+2 only. Busy=0 from N+2 on. The state returns to IDLE in N+2.
- WriteEnable is never high without a corresponding accept, so RxValid bubbles produce no writes.
- Start while in FILL or DONE is ignored; the latched parameters are unchanged.
- Abort in FILL:
  - Any byte presented in the same cycle is not accepted; Abort wins over RxValid.
  - The next state is IDLE with Busy=0 and no Done pulse.
  - A write already scheduled from the previous cycle's accept still completes.
  - ByteCount and Crc16 hold their values at abort.
- Abort in IDLE, including together with Start: no effect, and the fill does not start.
- Reset mid-fill: immediate return to reset values; a pending write is dropped.
- ByteCount and Crc16 hold after completion until the next accepted Start.

Optional Feature:
- Macro: SPI_FILL_CRC16_EN.
- Defined: Crc16 updates on every accepted byte, in the same cycle as ByteCount.
  - CRC-16/XMODEM: polynomial 0x1021, init 0x0000, MSB-first, no reflection, no final XOR. This is the SD data-block CRC.
  - The value is valid in the same cycle Done is high.
- Undefined: Crc16 is tied to 16'h0000 and no CRC logic is synthesized.

Decomposition:
- Package spi_buffer_pkg holds:
  - the state enum (IDLE, FILL, DONE);
  - localparam CRC16_POLY = 16'h1021;
  - default ADDR_W and BUF_BYTES = 1024.
- One sub-module: crc16_ccitt_byte, a combinational function of next CRC from (crc_in[15:0], byte[7:0]). It is instantiated only under SPI_FILL_CRC16_EN.

Test Plan:
- Start, StartAddr=0x000, Length=3, bytes 0x11,0x22,0x33,0x44 back-to-back -> writes to addresses 0..3 with those data, one cycle after each accept; Done exactly 2 cycles after the last accept; ByteCount=4.
- StartAddr=0x3FE, Length=3, bytes A0..A3 with RxValid bubbles -> addresses 0x3FE,0x3FF,0x000,0x001; no WriteEnable during bubbles.
- Length=1023 (1024 bytes, data = index & 0xFF) -> 1024 writes, ByteCount=0x400, Done once, RxReady=0 after the last accept.
- After 5 of 10 bytes, assert Abort with RxValid=1 -> that byte is not written, Busy falls the next cycle, no Done, ByteCount=5; a Start pulsed during FILL beforehand is ignored.
- SPI_FILL_CRC16_EN defined, ASCII "123456789" (Length=8) -> Crc16=0x31C3 when Done is high; undefined -> Crc16=0x0000.
- Reset asserted mid-fill -> next cycle all outputs at reset values and no further writes; a subsequent fill behaves normally.
